ratio_readout: RTL and testbench

Reads the averaged ratio spectrum back out of the 12-bit ratio memory and streams it as a framed byte sequence toward the host link. It sits on the read port of the ratio RAM, opposite the averaging/division writer. It handles frame building, memory-latency alignment, byte-level valid/ready flow control and a running checksum.

---
 rtl/raman_pkg.sv | 26 ++
 rtl/byte_tx_reg.sv | 45 ++++
 rtl/ratio_readout.sv | 212 +++++++++++++++++++++
 tb/tb_ratio_readout.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raman_pkg.sv
// Shared definitions for the ratio memory readout path and the ratio writer.
// Holds the readout FSM encoding, frame sync bytes and default memory geometry.
package raman_pkg;

  localparam int RAMAN_ADDR_W = 11;
  localparam int RAMAN_DATA_W = 12;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_WR,
    SYNC0,
    SYNC1,
    LEN_HI,
    LEN_LO,
    FETCH,
    WAIT_RD,
    SEND_HI,
    SEND_LO,
    CSUM,
    FIN
  } rr_state_e;

endpackage

// File: rtl/byte_tx_reg.sv
// Single-entry holding register for the outbound byte stream.
// Keeps tx_data/tx_valid stable until the sink takes the byte; fire marks the handshake.
module byte_tx_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       fire
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       accept;

  always_comb begin
    fire    = valid_q & tx_ready;
    // A new byte may only overwrite the slot if it is empty or leaving this edge.
    accept  = load & (~valid_q | fire);
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;

endmodule

// File: rtl/ratio_readout.sv
// Streams the ratio spectrum out of the ratio RAM as a framed, checksummed byte sequence.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT_WR | start seen, deferring while the writer owns the memory
// SYNC0   | presenting 0xA5, checksum and address cleared
// SYNC1   | presenting 0x5A
// LEN_HI  | presenting length high byte
// LEN_LO  | presenting length low byte
// FETCH   | one-cycle read strobe for the current address
// WAIT_RD | counting out memory latency, captures the sample
// SEND_HI | presenting sample high byte
// SEND_LO | presenting sample low byte
// CSUM    | presenting checksum byte
// FIN     | done pulse, back to IDLE
module ratio_readout
  import raman_pkg::*;
#(
  parameter int ADDR_W = RAMAN_ADDR_W,
  parameter int DATA_W = RAMAN_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_busy,
  input  logic [ADDR_W-1:0] POINTS,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  rr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] points_q, points_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        samp_lo_q, samp_lo_d;
  logic [7:0]        csum_q, csum_d;

  logic              ld;
  logic [7:0]        ld_data;
  logic              fire;
  logic [15:0]       pts_ext;
  logic [15:0]       dat_ext;

  assign pts_ext = 16'(points_q);
  assign dat_ext = 16'(rd_data);

  byte_tx_reg u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_data (ld_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .fire      (fire)
  );

  always_comb begin
    state_d   = state_q;
    points_d  = points_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    samp_lo_d = samp_lo_q;
    csum_d    = csum_q;
    ld        = 1'b0;
    ld_data   = 8'h00;
    rd_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    if (fire && (state_q inside {LEN_HI, LEN_LO, SEND_HI, SEND_LO})) begin
      csum_d = csum_q + tx_data;
    end

    // Each transition into a send state loads that state's byte on the same edge,
    // so the byte register always holds the byte of the current state.
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          points_d = POINTS;
          if (wr_busy) begin
            state_d = WAIT_WR;
          end else begin
            state_d = SYNC0;
            ld      = 1'b1;
            ld_data = SYNC0_BYTE;
          end
        end
      end
      WAIT_WR: begin
        if (!wr_busy) begin
          points_d = POINTS;
          state_d  = SYNC0;
          ld       = 1'b1;
          ld_data  = SYNC0_BYTE;
        end
      end
      SYNC0: begin
        csum_d = 8'h00;
        addr_d = '0;
        if (fire) begin
          ld      = 1'b1;
          ld_data = SYNC1_BYTE;
          state_d = SYNC1;
        end
      end
      SYNC1: begin
        if (fire) begin
          ld      = 1'b1;
          ld_data = pts_ext[15:8];
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fire) begin
          ld      = 1'b1;
          ld_data = pts_ext[7:0];
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (fire) begin
          if (points_q == '0) begin
            ld      = 1'b1;
            ld_data = csum_q + tx_data;
            state_d = CSUM;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        lat_d   = LAT_M1;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_q == 2'd0) begin
          samp_lo_d = dat_ext[7:0];
          ld        = 1'b1;
          ld_data   = dat_ext[15:8];
          state_d   = SEND_HI;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      SEND_HI: begin
        if (fire) begin
          ld      = 1'b1;
          ld_data = samp_lo_q;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (fire) begin
          if (addr_q == points_q - 1'b1) begin
            ld      = 1'b1;
            ld_data = csum_q + tx_data;
            state_d = CSUM;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      CSUM: begin
        if (fire) begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      points_q  <= '0;
      addr_q    <= '0;
      lat_q     <= 2'd0;
      samp_lo_q <= 8'h00;
      csum_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      points_q  <= points_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      samp_lo_q <= samp_lo_d;
      csum_q    <= csum_d;
    end
  end

  assign rd_addr = addr_q;

endmodule

// File: tb/tb_ratio_readout.sv
// Bench for ratio_readout: three instances (RD_LAT 2, 1, 3) share stimulus and are
// compared byte-for-byte against a frame model built from the memory contents.
module tb_ratio_readout;

  localparam int AW = 11;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          wr_busy = 1'b0;
  logic [AW-1:0] points = '0;
  logic          rdy_fix = 1'b1;
  logic          rdy_rand = 1'b1;
  logic          rand_rdy = 1'b0;
  logic          tx_ready;

  logic [DW-1:0] mem [0:2047];
  logic          rd_en [3];
  logic [AW-1:0] rd_addr [3];
  logic [DW-1:0] rd_data [3];
  logic [DW-1:0] pipe [3][3];
  logic [7:0]    tx_data [3];
  logic          tx_valid [3];
  logic          busy [3];
  logic          done [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q [$];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic [7:0] got2 [$];
  int         exp_len = 0;
  int         done_cnt [3];
  int         done_edge = -1;
  int         csum_edge = -1;
  logic       busy_at_done = 1'b0;
  int         rd_cnt = 0;
  int         last_rd = -1;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  assign tx_ready = rand_rdy ? rdy_rand : rdy_fix;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));

  ratio_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_busy(wr_busy), .POINTS(points),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
    .busy(busy[0]), .done(done[0]));

  ratio_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_busy(wr_busy), .POINTS(points),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
    .busy(busy[1]), .done(done[1]));

  ratio_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_busy(wr_busy), .POINTS(points),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready),
    .busy(busy[2]), .done(done[2]));

  // Memory read pipelines: garbage on idle cycles so a mistimed capture shows up.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][2] <= pipe[i][1];
      pipe[i][1] <= pipe[i][0];
      pipe[i][0] <= rd_en[i] ? mem[rd_addr[i]] : DW'($urandom);
    end
  end
  assign rd_data[0] = pipe[0][1];
  assign rd_data[1] = pipe[1][0];
  assign rd_data[2] = pipe[2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid[0] && tx_ready) begin
      got0.push_back(tx_data[0]);
      if (got0.size() == exp_len) csum_edge = cyc + 1;
    end
    if (tx_valid[1] && tx_ready) got1.push_back(tx_data[1]);
    if (tx_valid[2] && tx_ready) got2.push_back(tx_data[2]);
    for (int i = 0; i < 3; i++) if (done[i]) done_cnt[i]++;
    if (done[0]) begin
      done_edge    = cyc;
      busy_at_done = busy[0];
    end
    if (rd_en[0]) begin
      rd_cnt++;
      last_rd = int'(rd_addr[0]);
    end
    if (hold_prev) begin
      chk("hold_valid", 32'(tx_valid[0]), 32'd1);
      chk("hold_data", 32'(tx_data[0]), 32'(hold_data));
    end
    hold_prev = tx_valid[0] && !tx_ready;
    hold_data = tx_data[0];
  end

  // Frame model straight from the byte-order rules.
  task automatic model(input int p);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(p / 256));
    exp_q.push_back(8'(p % 256));
    for (int a = 0; a < p; a++) begin
      exp_q.push_back(8'(int'(mem[a]) / 256));
      exp_q.push_back(8'(int'(mem[a]) % 256));
    end
    for (int k = 2; k < exp_q.size(); k++) sum += int'(exp_q[k]);
    exp_q.push_back(8'(sum % 256));
    exp_len = exp_q.size();
  endtask

  task automatic clear_mon();
    got0.delete();
    got1.delete();
    got2.delete();
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    done_edge = -1;
    csum_edge = -1;
    rd_cnt = 0;
    last_rd = -1;
  endtask

  task automatic cmp_bytes(input string tag, input int inst);
    logic [7:0] g [$];
    int f0;
    case (inst)
      0:       g = got0;
      1:       g = got1;
      default: g = got2;
    endcase
    chk($sformatf("%s_i%0d_len", tag, inst), 32'(g.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < g.size(); k++) begin
      f0 = failures;
      chk($sformatf("%s_i%0d_b%0d", tag, inst, k), 32'(g[k]), 32'(exp_q[k]));
      if (failures != f0) break;
    end
  endtask

  task automatic cmp_all(input string tag);
    for (int i = 0; i < 3; i++) cmp_bytes(tag, i);
  endtask

  task automatic pulse_start(output int edge_n);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    edge_n = cyc;
    start = 1'b0;
  endtask

  task automatic wait_all(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frames_done"}, 32'(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_mem(input int p);
    for (int a = 0; a < p; a++) mem[a] = DW'($urandom);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int p;
    int n;
    for (int a = 0; a < 2048; a++) mem[a] = DW'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk("rst_tx_data", 32'(tx_data[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_rd_en", 32'(rd_en[0]), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed 3-point frame, sink always ready
    mem[0] = 12'h123; mem[1] = 12'hFFF; mem[2] = 12'h000;
    points = 11'd3;
    model(3);
    clear_mon();
    pulse_start(e);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    chk("t1_first_valid", 32'(tx_valid[0]), 32'd1);
    chk("t1_first_byte", 32'(tx_data[0]), 32'hA5);
    wait_all("t1", 400);
    cmp_all("t1");
    chk("t1_csum_edge", 32'(csum_edge), 32'(e + 4 + 3 * (3 + 2) + 1));
    chk("t1_done_edge", 32'(done_edge), 32'(csum_edge));
    chk("t1_done_once", 32'(done_cnt[0]), 32'd1);
    chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd3);

    // Zero-length frame
    points = 11'd0;
    model(0);
    clear_mon();
    pulse_start(e);
    wait_all("t2", 400);
    cmp_all("t2");
    chk("t2_no_rd", 32'(rd_cnt), 32'd0);

    // Same 3-point frame with a stalling sink
    mem[0] = 12'h123; mem[1] = 12'hFFF; mem[2] = 12'h000;
    points = 11'd3;
    model(3);
    clear_mon();
    rand_rdy = 1'b1;
    pulse_start(e);
    wait_all("t3", 2000);
    cmp_all("t3");

    // Random frames with a stalling sink
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(1, 24);
      rand_mem(p);
      points = AW'(p);
      model(p);
      clear_mon();
      pulse_start(e);
      points = AW'($urandom);
      wait_all($sformatf("t3r%0d", it), 5000);
      cmp_all($sformatf("t3r%0d", it));
      chk($sformatf("t3r%0d_last_rd", it), 32'(last_rd), 32'(p - 1));
    end
    rand_rdy = 1'b0;

    // Start deferred by the writer, plus a start while busy
    p = $urandom_range(1, 6);
    rand_mem(p);
    points = AW'(p);
    model(p);
    clear_mon();
    wr_busy = 1'b1;
    pulse_start(e);
    chk("t4_busy_immediate", 32'(busy[0]), 32'd1);
    chk("t4_held_valid", 32'(tx_valid[0]), 32'd0);
    repeat (19) @(posedge clk);
    #1 wr_busy = 1'b0;
    chk("t4_still_held", 32'(tx_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_sync_valid", 32'(tx_valid[0]), 32'd1);
    chk("t4_sync_byte", 32'(tx_data[0]), 32'hA5);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_all("t4", 400);
    repeat (40) @(negedge clk);
    cmp_all("t4");
    chk("t4_single_done", 32'(done_cnt[0]), 32'd1);
    chk("t4_idle_after", 32'(busy[0]), 32'd0);

    // Full-size ramp
    for (int a = 0; a < 2048; a++) mem[a] = DW'(a);
    points = 11'd2047;
    model(2047);
    clear_mon();
    pulse_start(e);
    wait_all("t5", 30000);
    cmp_all("t5");
    chk("t5_last_rd", 32'(last_rd), 32'd2046);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd2047);

    // Reset during the fifth sample's low byte
    p = 8;
    rand_mem(p);
    points = AW'(p);
    model(p);
    clear_mon();
    pulse_start(e);
    n = 0;
    while (got0.size() < 13 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_s5", 32'(got0.size() >= 13), 32'd1);
    @(negedge clk);
    chk("t6_s5_lo_byte", 32'(tx_data[0]), 32'(exp_q[13]));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid[0]), 32'd0);
    chk("t6_rst_data", 32'(tx_data[0]), 32'd0);
    chk("t6_rst_busy", 32'(busy[0]), 32'd0);
    chk("t6_rst_rd_en", 32'(rd_en[0]), 32'd0);
    chk("t6_rst_rd_addr", 32'(rd_addr[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    p = $urandom_range(4, 12);
    rand_mem(p);
    points = AW'(p);
    model(p);
    clear_mon();
    pulse_start(e);
    wait_all("t6", 600);
    cmp_all("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
